// File: rtl/upload_arbiter_pkg.sv
// Shared types and constants for the upload arbiter and the peripheral handlers
// that feed it.
package upload_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;

  // Source IDs stamped on uploaded bytes by each handler.
  localparam logic [7:0] SRC_UART = 8'h01;
  localparam logic [7:0] SRC_SPI  = 8'h02;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/upload_arbiter_if.sv
// Byte-upload link bundle, N lanes wide: each lane carries req/valid/ready
// plus one data byte and one source-ID byte.
interface upload_arbiter_if
  import upload_arb_pkg::*;
#(
  parameter int N = 1
);
  logic [N-1:0]        req;
  logic [BYTE_W*N-1:0] data;
  logic [BYTE_W*N-1:0] source;
  logic [N-1:0]        valid;
  logic [N-1:0]        ready;

  modport master (output req, data, source, valid, input ready);
  modport slave  (input req, data, source, valid, output ready);
endinterface

// File: rtl/upload_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req_mask searching
// upward from last_g+1, wrapping modulo NUM_CH.
module rr_pick
  import upload_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_mask,
  input  logic [IDX_W-1:0]  last_g,
  output logic              found,
  output logic [IDX_W-1:0]  pick
);

  logic [IDX_W-1:0]  cand_idx [NUM_CH];
  logic [NUM_CH-1:0] cand_hit;

  // Candidate k is the channel k+1 positions after the previous owner.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((32'(last_g) + 32'(gi) + 32'd1) % 32'(NUM_CH));
    assign cand_hit[gi] = req_mask[cand_idx[gi]];
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found = 1'b1;
        pick  = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/upload_arbiter.sv
// Packet-locked round-robin arbiter merging N handler upload links onto the
// command processor upload port, with a watchdog that reclaims a stalled grant.
module upload_arbiter
  import upload_arb_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  upload_arbiter_if.slave   ch,
  upload_arbiter_if.master  up,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic              timeout_pulse
);

  localparam int               IDX_W     = idx_w(NUM_CH);
  localparam int               CNT_W     = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_CH - 1);
  localparam bit               WD_EN     = (TIMEOUT_CYCLES != 0);

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  g_reg, g_next;
  logic [IDX_W-1:0]  last_g_reg, last_g_next;
  logic [NUM_CH-1:0] blocked_reg, blocked_next;
  logic [CNT_W-1:0]  wd_cnt_reg, wd_cnt_next;

  logic [NUM_CH-1:0] eligible;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_req, owner_valid;
  logic              in_grant, xfer, owner_release, wd_expire;

  assign eligible = ch.req & ~blocked_reg;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_mask (eligible),
    .last_g   (last_g_reg),
    .found    (pick_found),
    .pick     (pick_idx)
  );

  assign in_grant      = (state_reg == ST_GRANT);
  assign owner_req     = ch.req[g_reg];
  assign owner_valid   = ch.valid[g_reg];
  assign xfer          = in_grant && owner_valid && up.ready[0];
  assign owner_release = in_grant && !owner_req && !owner_valid;
  // A byte completing in the expiry cycle resets the count, so it wins.
  assign wd_expire     = WD_EN && in_grant && !owner_release && !xfer &&
                         (wd_cnt_reg == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      g_reg       <= '0;
      last_g_reg  <= LAST_INIT;
      blocked_reg <= '0;
      wd_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      g_reg       <= g_next;
      last_g_reg  <= last_g_next;
      blocked_reg <= blocked_next;
      wd_cnt_reg  <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    g_next       = g_reg;
    last_g_next  = last_g_reg;
    blocked_next = blocked_reg & ch.req;
    wd_cnt_next  = wd_cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next  = ST_GRANT;
          g_next      = pick_idx;
          wd_cnt_next = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          wd_cnt_next = '0;
        end else if (wd_cnt_reg != CNT_MAX) begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
        if (owner_release) begin
          state_next  = ST_IDLE;
          last_g_next = g_reg;
        end else if (wd_expire) begin
          state_next            = ST_FLUSH;
          last_g_next           = g_reg;
          blocked_next[g_reg]   = 1'b1;
        end
      end
      ST_FLUSH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outside GRANT everything is forced low, which also gives the one-cycle
  // up_req gap between consecutive packets.
  always_comb begin
    up.req        = '0;
    up.valid      = '0;
    up.data       = '0;
    up.source     = '0;
    ch.ready      = '0;
    grant         = '0;
    busy          = 1'b0;
    timeout_pulse = 1'b0;
    if (in_grant) begin
      up.req          = owner_req;
      up.valid        = owner_valid;
      up.data         = ch.data[{g_reg, 3'b000} +: BYTE_W];
      up.source       = ch.source[{g_reg, 3'b000} +: BYTE_W];
      ch.ready[g_reg] = up.ready[0];
      grant[g_reg]    = 1'b1;
      busy            = 1'b1;
      timeout_pulse   = wd_expire;
    end
  end

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed bench for upload_arbiter (4 channels, 16-cycle watchdog): single
// source, contention, fairness, back-pressure, watchdog and reset mid-packet.
module tb_upload_arbiter;
  import upload_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] grant;
  logic       busy;
  logic       timeout_pulse;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] xfer_q[$];

  upload_arbiter_if #(.N(4)) ch_if();
  upload_arbiter_if #(.N(1)) up_if();

  upload_arbiter #(
    .NUM_CH         (4),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch            (ch_if),
    .up            (up_if),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && up_if.valid[0] && up_if.ready[0]) begin
      xfer_q.push_back({up_if.source, up_if.data});
      $display("xfer src=%02h data=%02h", up_if.source, up_if.data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic r, input logic v, input logic [7:0] d);
    ch_if.req[i]         = r;
    ch_if.valid[i]       = v;
    ch_if.data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    ch_if.req   = '0;
    ch_if.valid = '0;
    ch_if.data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] b;
    rst_n        = 1'b0;
    ch_if.req    = '0;
    ch_if.valid  = '0;
    ch_if.data   = '0;
    ch_if.source = {8'h04, 8'h03, SRC_SPI, SRC_UART};
    up_if.ready  = 1'b1;
    set_ch(0, 1'b1, 1'b1, 8'h55);

    // Reset with a live request: nothing may be granted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant",   32'(grant), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    chk("rst_up_req",  32'(up_if.req), 32'h0);
    chk("rst_up_data", 32'(up_if.data), 32'h0);
    chk("rst_ready",   32'(ch_if.ready), 32'h0);
    chk("rst_tmo",     32'(timeout_pulse), 32'h0);
    do_reset();

    // Single source: ch1 sends A0..A3.
    set_ch(1, 1'b1, 1'b1, 8'hA0);
    #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      b = 8'hA0 + 8'(k);
      set_ch(1, 1'b1, 1'b1, b);
      #1;
      chk("t1_grant",  32'(grant), 32'h2);
      chk("t1_ready",  32'(ch_if.ready), 32'h2);
      chk("t1_data",   32'(up_if.data), 32'(b));
      chk("t1_source", 32'(up_if.source), 32'(SRC_SPI));
      @(negedge clk);
    end
    set_ch(1, 1'b0, 1'b0, 8'h00);
    #1;
    chk("t1_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    chk("t1_busy_fall", 32'(busy), 32'h0);
    chk("t1_nbytes", 32'(xfer_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < xfer_q.size(); k++)
      chk("t1_byte", 32'(xfer_q[k]), 32'({SRC_SPI, 8'hA0 + 8'(k)}));

    // Contention after reset: ch0 first, ch1 two cycles after ch0 releases.
    do_reset();
    set_ch(0, 1'b1, 1'b1, 8'h10);
    set_ch(1, 1'b1, 1'b1, 8'h20);
    @(negedge clk);
    #1;
    chk("t2_grant0", 32'(grant), 32'h1);
    chk("t2_ready0", 32'(ch_if.ready), 32'h1);
    chk("t2_data0",  32'(up_if.data), 32'h10);
    @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 8'h11);
    #1;
    chk("t2_data1",  32'(up_if.data), 32'h11);
    chk("t2_ready1", 32'(ch_if.ready), 32'h1);
    @(negedge clk);
    set_ch(0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("t2_rel_grant", 32'(grant), 32'h1);
    @(negedge clk);
    #1;
    chk("t2_gap_grant",  32'(grant), 32'h0);
    chk("t2_gap_up_req", 32'(up_if.req), 32'h0);
    @(negedge clk);
    #1;
    chk("t2_grant1",  32'(grant), 32'h2);
    chk("t2_source1", 32'(up_if.source), 32'(SRC_SPI));
    @(negedge clk);
    set_ch(1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("t2_nbytes", 32'(xfer_q.size()), 32'd3);
    if (xfer_q.size() == 3) begin
      chk("t2_q0", 32'(xfer_q[0]), 32'({SRC_UART, 8'h10}));
      chk("t2_q1", 32'(xfer_q[1]), 32'({SRC_UART, 8'h11}));
      chk("t2_q2", 32'(xfer_q[2]), 32'({SRC_SPI, 8'h20}));
    end

    // Fairness: all four request continuously with 1-byte packets.
    do_reset();
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b1, 8'h60 + 8'(i));
    @(negedge clk);
    for (int p = 0; p < 6; p++) begin
      #1;
      chk("t3_order", 32'(grant), 32'h1 << (p % 4));
      @(negedge clk);
      set_ch(p % 4, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      set_ch(p % 4, 1'b1, 1'b1, 8'h60 + 8'(p % 4));
      #1;
      chk("t3_idle", 32'(grant), 32'h0);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) set_ch(i, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    chk("t3_nbytes", 32'(xfer_q.size()), 32'd6);
    for (int p = 0; p < 6 && p < xfer_q.size(); p++)
      chk("t3_byte", 32'(xfer_q[p][7:0]), 32'h60 + 32'(p % 4));

    // Back-pressure: up_ready low for 10 cycles in the middle of ch2's packet.
    xfer_q.delete();
    set_ch(2, 1'b1, 1'b1, 8'h30);
    @(negedge clk);
    #1;
    chk("t4_grant", 32'(grant), 32'h4);
    @(negedge clk);
    set_ch(2, 1'b1, 1'b1, 8'h31);
    up_if.ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_stall_ready", 32'(ch_if.ready), 32'h0);
      chk("t4_stall_data",  32'(up_if.data), 32'h31);
      @(negedge clk);
    end
    up_if.ready = 1'b1;
    #1;
    chk("t4_resume_ready", 32'(ch_if.ready), 32'h4);
    @(negedge clk);
    set_ch(2, 1'b1, 1'b1, 8'h32);
    @(negedge clk);
    set_ch(2, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    chk("t4_nbytes", 32'(xfer_q.size()), 32'd3);
    if (xfer_q.size() == 3) begin
      chk("t4_q0", 32'(xfer_q[0]), 32'h0330);
      chk("t4_q1", 32'(xfer_q[1]), 32'h0331);
      chk("t4_q2", 32'(xfer_q[2]), 32'h0332);
    end

    // Watchdog: ch3 holds req without valid after one byte; ch0 waits.
    xfer_q.delete();
    set_ch(3, 1'b1, 1'b1, 8'h40);
    @(negedge clk);
    #1;
    chk("t5_grant3", 32'(grant), 32'h8);
    @(negedge clk);
    set_ch(3, 1'b1, 1'b0, 8'h40);
    set_ch(0, 1'b1, 1'b1, 8'h50);
    // Counter sits at 0..15 over these cycles; expiry when it reaches 16.
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t5_no_tmo", 32'(timeout_pulse), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("t5_tmo_pulse", 32'(timeout_pulse), 32'h1);
    chk("t5_tmo_grant", 32'(grant), 32'h8);
    @(negedge clk);
    #1;
    chk("t5_flush_busy",  32'(busy), 32'h0);
    chk("t5_flush_pulse", 32'(timeout_pulse), 32'h0);
    chk("t5_flush_req",   32'(up_if.req), 32'h0);
    @(negedge clk);
    #1;
    chk("t5_idle_grant", 32'(grant), 32'h0);
    @(negedge clk);
    #1;
    chk("t5_next_grant", 32'(grant), 32'h1);
    @(negedge clk);
    set_ch(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_blocked", 32'(grant), 32'h0);
    set_ch(3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    set_ch(3, 1'b1, 1'b1, 8'h41);
    @(negedge clk);
    #1;
    chk("t5_unblocked", 32'(grant), 32'h8);
    @(negedge clk);
    set_ch(3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk("t5_nbytes", 32'(xfer_q.size()), 32'd3);
    if (xfer_q.size() == 3) begin
      chk("t5_q0", 32'(xfer_q[0]), 32'h0440);
      chk("t5_q1", 32'(xfer_q[1]), 32'({SRC_UART, 8'h50}));
      chk("t5_q2", 32'(xfer_q[2]), 32'h0441);
    end

    // Reset mid-packet: last owner before the reset is ch0, so a surviving
    // last_g would hand the post-reset contention to ch1.
    set_ch(0, 1'b1, 1'b1, 8'h6F);
    @(negedge clk);
    #1;
    chk("t6_grant0", 32'(grant), 32'h1);
    @(negedge clk);
    set_ch(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    set_ch(1, 1'b1, 1'b1, 8'h70);
    @(negedge clk);
    #1;
    chk("t6_grant1", 32'(grant), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy",  32'(busy), 32'h0);
    chk("t6_rst_req",   32'(up_if.req), 32'h0);
    chk("t6_rst_valid", 32'(up_if.valid), 32'h0);
    chk("t6_rst_ready", 32'(ch_if.ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ch(0, 1'b1, 1'b1, 8'h71);
    @(negedge clk);
    #1;
    chk("t6_post_rst_grant", 32'(grant), 32'h1);
    set_ch(0, 1'b0, 1'b0, 8'h00);
    set_ch(1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/upload_arbiter.md
# upload_arbiter

Parametrised N-channel upload arbiter between the peripheral handlers (UART, SPI, and later I2C/ADC) and the `command_processor` upload port. It replaces the unarbitrated OR-merge of handler upload signals with a packet-locked, round-robin grant. A watchdog reclaims the port from a stalled source. The block sits in the integration top between the handler instances and `u_command_processor`.

## Interface
Parameters:
- `NUM_CH`, 2: number of upload sources; legal range 2..8.
- `TIMEOUT_CYCLES`, 65535: cycles without a completed byte before a held grant is revoked; 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_upload_req`  in  NUM_CH  per-channel packet request; stays high for the whole packet.
- `ch_upload_data`  in  8*NUM_CH  per-channel byte; channel i occupies bits [8i+7:8i].
- `ch_upload_source`  in  8*NUM_CH  per-channel source ID, same packing as data.
- `ch_upload_valid`  in  NUM_CH  per-channel byte valid.
- `ch_upload_ready`  out  NUM_CH  per-channel ready; at most one bit set.
- `up_req`  out  1  merged request to `command_processor.upload_req_in`.
- `up_data`  out  8  merged byte.
- `up_source`  out  8  merged source ID.
- `up_valid`  out  1  merged valid.
- `up_ready`  in  1  from `command_processor.upload_ready_out`.
- `grant`  out  NUM_CH  one-hot current owner; 0 when idle.
- `busy`  out  1  a grant is held.
- `timeout_pulse`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner index `g` registered.
  - FLUSH: single dead cycle after a forced release.
- IDLE → GRANT:
  - Triggered when any eligible `ch_upload_req` bit is high.
  - The winner is the first requesting channel found searching from `last_g+1` upward, wrapping modulo NUM_CH.
  - `last_g` resets to NUM_CH-1, so channel 0 wins the first contention.
- In GRANT:
  - `up_req`, `up_valid`, `up_data` and `up_source` are driven combinationally from channel g.
  - `ch_upload_ready[g]` = `up_ready`; all other ready bits are 0.
  - A byte transfers when `up_valid` and `up_ready` are both high.
- GRANT → IDLE: when `ch_upload_req[g]` and `ch_upload_valid[g]` are both low. `last_g` is then set to g.
- In IDLE and FLUSH:
  - All `up_*` outputs and all `ch_upload_ready` bits are 0.
  - This guarantees `up_req` is low for at least 1 cycle between packets.
- Watchdog:
  - The counter clears on grant and on every transfer, and increments while in GRANT.
  - When the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES ≠ 0): pulse `timeout_pulse`, go GRANT → FLUSH, set `last_g` = g, and set `blocked[g]`.
  - FLUSH → IDLE unconditionally.
- `blocked[i]`:
  - A blocked channel is ineligible for arbitration.
  - The bit clears on the first cycle in which `ch_upload_req[i]` is low.
- A `ch_upload_valid` on a non-granted channel is ignored; that channel's ready stays 0 and its byte is held by the handler.

## Timing
- Arbitration latency: request seen in IDLE at cycle t → `grant` and `busy` high at t+1; first transfer possible at t+1.
- Data path is zero-latency combinational; only the FSM, `g`, `last_g`, `blocked` and the watchdog counter are registered.
- Release: owner drops req/valid at cycle t → IDLE at t+1 → next grant earliest at t+2.
- Simultaneous release and a new request from another channel: the new grant still waits for the IDLE cycle.
- Simultaneous last transfer and watchdog expiry: the transfer resets the counter, so no timeout occurs.
- Reset values: state IDLE, `grant`=0, `busy`=0, `timeout_pulse`=0, `ch_upload_ready`=0, all `up_*`=0, `blocked`=0, `last_g`=NUM_CH-1, counter 0.
- Asynchronous reset asserted mid-packet: the grant is dropped immediately and no partial state survives.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it saturates at TIMEOUT_CYCLES and never wraps.

## Structure
- Package `upload_arb_pkg`:
  - FSM state encoding (IDLE/GRANT/FLUSH).
  - Index-width function `IDX_W = $clog2(NUM_CH)`.
  - Source-ID constants shared with the handlers (UART, SPI).
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs are the request mask and `last_g`; outputs are `found` and the winning index. It is reusable for a future cmd-ready arbiter.

## Test plan
- Single source: ch1 sends 4 bytes 0xA0..0xA3 with `up_ready`=1 → `grant`=2'b10 one cycle after req; the 4 bytes appear on `up_data` with `up_source` = ch1 ID; `busy` falls 1 cycle after req drops.
- Contention: ch0 and ch1 request in the same cycle after reset → ch0 granted first; ch1 granted 2 cycles after ch0 releases; no ch1 byte transfers during the ch0 packet; `up_req` low for ≥1 cycle between packets.
- Fairness (NUM_CH=4): all 4 channels request continuously with 1-byte packets → grant order 0,1,2,3,0,…
- Back-pressure: `up_ready` held low for 10 cycles mid-packet → `ch_upload_ready[g]` low; data stable; no bytes lost or duplicated.
- Watchdog (TIMEOUT_CYCLES=16): owner holds req with no valid → `timeout_pulse` at cycle 16 after the last transfer, then FLUSH, then the next channel is granted. The timed-out channel is not re-granted until its req drops.
- Reset mid-packet → all outputs 0 immediately; a fresh request after reset is granted to ch0 first.
